// File: rtl/mem_req_initiator.sv
// Single-outstanding memory request initiator fed by a QDEPTH-entry request FIFO.
// Define MEM_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT_CYCLES without mem_resp.
module mem_req_initiator #(
    parameter int QDEPTH         = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wmask,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    input  logic        mem_error
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;

    // Only the word address is kept; byte offset bits never reach memory.
    typedef struct packed {
        logic        we;
        logic [29:0] waddr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic          ready_en_q, ready_en_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    req_t          fifo_q [QDEPTH];
    req_t          issue_q, issue_d;
    req_t          push_entry;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          push, pop, busy, tmo_hit;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    // ready_en_q keeps req_ready low during reset and for the release edge.
    assign req_ready  = ready_en_q & (count_q < CW'(QDEPTH));
    assign push       = req_valid & req_ready;
    assign pop        = (state_q == IDLE) & (count_q != '0);
    assign busy       = (state_q == BUSY);
    assign push_entry = '{we: req_we, waddr: req_addr[31:2], wmask: req_wmask, wdata: req_wdata};

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero in IDLE so every BUSY entry starts a fresh count.
    always_comb tmo_cnt_d = busy ? tmo_cnt_q + TW'(1) : '0;

    assign tmo_hit = busy && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_cnt_q <= '0;
        else      tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_tmo_cfg;

    assign tmo_hit        = 1'b0;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        ready_en_d = 1'b1;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    issue_d = fifo_q[rd_ptr_q];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = issue_q.we ? '0 : mem_rdata;
                    rsp_err_d   = mem_error;
                    state_d     = IDLE;
                end else if (tmo_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ready_en_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            issue_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= ready_en_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            issue_q     <= issue_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Strobes fall combinationally in the mem_resp cycle so memory never sees a repeat.
    assign mem_read  = busy & ~issue_q.we & ~mem_resp;
    assign mem_write = busy &  issue_q.we & ~mem_resp;
    assign mem_addr  = busy ? {issue_q.waddr, 2'b00} : '0;
    assign mem_wmask = (busy & issue_q.we) ? issue_q.wmask : '0;
    assign mem_wdata = (busy & issue_q.we) ? issue_q.wdata : '0;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Scoreboard bench: a behavioural memory and request/response queues check mem_req_initiator.
// Build with MEM_TIMEOUT_EN defined to also exercise the timeout abort.
`timescale 1ns/1ps
module tb_mem_req_initiator;
    localparam int QDEPTH = 2;
    localparam int TMO    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_resp, mem_error;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    mem_req_initiator #(.QDEPTH(QDEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .mem_error(mem_error)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    req_t        iss_q[$];
    rsp_t        rsp_q[$];
    int          vectors = 0, miscompares = 0;
    int          nacc = 0, ncomp = 0;
    int          mem_dly = 0, err_mode = 0;
    bit          mem_hang = 0, mem_off = 0, use_fix = 0;
    logic [31:0] fix_data = '0;
    bit          mbusy = 0;
    int          mcnt = 0, mdly = 0;
    req_t        mcur = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"},   rsp_err, 0);
        chk({tag, "_mem_addr"},  mem_addr, 0);
        chk({tag, "_mem_strb"},  {mem_read, mem_write}, 0);
        chk({tag, "_mem_wmask"}, mem_wmask, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Behavioural memory: one transaction at a time, replies after mdly strobe cycles.
    always @(negedge clk) begin
        if (rst && !mem_off) begin
            if (mem_resp) begin
                chk("idle_gap_after_resp", {mem_read, mem_write}, 0);
                mem_resp  = 1'b0;
                mem_error = 1'b0;
                mbusy     = 1'b0;
            end else if (mem_read || mem_write) begin
                if (!mbusy) begin
                    if (iss_q.size() == 0) begin
                        chk("strobe_without_request", {mem_read, mem_write}, 0);
                    end else begin
                        mcur  = iss_q.pop_front();
                        mbusy = 1'b1;
                        mcnt  = 0;
                        mdly  = (mem_dly > 0) ? mem_dly : $urandom_range(1, 5);
                    end
                end
                if (mbusy) begin
                    chk("mem_addr",  mem_addr,  mcur.addr & 32'hFFFF_FFFC);
                    chk("mem_read",  mem_read,  !mcur.we);
                    chk("mem_write", mem_write, mcur.we);
                    chk("mem_wmask", mem_wmask, mcur.we ? mcur.wmask : 4'h0);
                    chk("mem_wdata", mem_wdata, mcur.we ? mcur.wdata : 32'h0);
                    if (!mem_hang) begin
                        if (mcnt >= mdly) begin
                            mem_rdata = use_fix ? fix_data : $urandom;
                            mem_error = (err_mode == 1) || (err_mode == 2 && $urandom_range(0, 7) == 0);
                            mem_resp  = 1'b1;
                            rsp_q.push_back('{rdata: mcur.we ? 32'h0 : mem_rdata, err: mem_error});
                            #1 chk("strobe_low_in_resp_cycle", {mem_read, mem_write}, 0);
                        end else begin
                            mcnt++;
                        end
                    end
                end
            end else if (!mbusy) begin
                chk("idle_wmask", mem_wmask, 0);
                chk("idle_wdata", mem_wdata, 0);
            end
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid) begin
            ncomp++;
            if (rsp_q.size() == 0) begin
                chk("spurious_rsp_valid", rsp_valid, 0);
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err",   rsp_err,   e.err);
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [3:0] wm, input logic [31:0] wd);
        req_t r;
        r = '{we: we, addr: addr, wmask: wm, wdata: wd};
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wmask = wm;
        req_wdata = wd;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                iss_q.push_back(r);
                nacc++;
                @(negedge clk);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("req_ready_stuck_low", req_ready, 1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(iss_q.size() == 0 && rsp_q.size() == 0 && !mbusy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (n >= 3000) chk("drain_timeout_outstanding", iss_q.size() + rsp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wmask = '0; req_wdata = '0;
        mem_resp = 1'b0; mem_error = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        chk("req_ready_after_release", req_ready, 1);

        // Load at unaligned address with a fixed read value.
        mem_dly = 1; use_fix = 1; fix_data = 32'hDEAD_BEEF; err_mode = 0;
        send(1'b0, 32'h0000_1006, 4'hF, 32'h0);
        @(posedge clk); #1;
        chk("accept_to_strobe_read", mem_read, 1);
        chk("load_mem_addr", mem_addr, 32'h0000_1004);
        @(negedge clk);
        drain();

        // Store.
        use_fix = 0;
        send(1'b1, 32'h0000_0040, 4'b0011, 32'h1234_5678);
        @(posedge clk); #1;
        chk("accept_to_strobe_write", mem_write, 1);
        chk("store_mem_wmask", mem_wmask, 4'b0011);
        chk("store_mem_wdata", mem_wdata, 32'h1234_5678);
        @(negedge clk);
        drain();

        // Load completing with an error.
        err_mode = 1;
        send(1'b0, 32'h0000_2000, 4'h0, 32'h0);
        drain();
        err_mode = 0;

        // Three back-to-back requests against a slow memory fill the queue.
        mem_dly = 5;
        send(1'b0, 32'h0000_0100, 4'h0, 32'h0);
        send(1'b1, 32'h0000_0204, 4'hC, 32'hA5A5_0001);
        send(1'b0, 32'h0000_030B, 4'h0, 32'h0);
        chk("req_ready_when_full", req_ready, 0);
        drain();

        // Reset while one request is in flight and another is queued.
        send(1'b0, 32'h0000_0500, 4'h0, 32'h0);
        send(1'b1, 32'h0000_0600, 4'hF, 32'hCAFE_F00D);
        #2;
        rst = 1'b0;
        iss_q.delete(); rsp_q.delete();
        mbusy = 1'b0; mem_resp = 1'b0; mem_error = 1'b0;
        nacc = 0; ncomp = 0;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 1'b1;
        @(negedge clk);
        chk("req_ready_after_mid_reset", req_ready, 1);
        repeat (6) @(negedge clk);
        send(1'b0, 32'h0000_0704, 4'h0, 32'h0);
        drain();

        // mem_resp while idle must not produce a completion.
        mem_off = 1'b1;
        mem_resp = 1'b1; mem_rdata = 32'h1111_2222;
        repeat (2) begin
            @(negedge clk);
            chk("idle_resp_ignored", rsp_valid, 0);
        end
        mem_resp = 1'b0;
        @(negedge clk);
        chk("idle_resp_ignored_after", rsp_valid, 0);
        mem_off = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // Memory never answers: strobe must hold TMO cycles then abort with an error.
        mem_hang = 1'b1;
        rsp_q.push_back('{rdata: 32'h0, err: 1'b1});
        send(1'b0, 32'h0000_0800, 4'h0, 32'h0);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_read) hi++;
            else if (hi > 0) break;
            @(negedge clk);
        end
        chk("timeout_strobe_cycles", hi, TMO);
        #2;
        mbusy = 1'b0; mem_hang = 1'b0;
        @(negedge clk);
        drain();
`endif

        // Randomized traffic with random gaps, latencies and errors.
        mem_dly = 0; err_mode = 2;
        for (int n = 0; n < 200; n++) begin
            send(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        chk("completion_count", ncomp, nacc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
